// File: rtl/sti_seq_ctrl.sv
// Host-side sequencer for the STI_DAC serializer: accepts words, issues load, and checks so_valid burst length.
// Optional watchdog on the so_valid start is built only when STI_SEQ_TIMEOUT_EN is defined.
module sti_seq_ctrl #(
   parameter int TIMEOUT_CYC = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [15:0] cmd_data,
   input  logic [1:0]  cmd_length,
   input  logic        cmd_fill,
   input  logic        cmd_msb,
   input  logic        cmd_low,
   input  logic        cmd_last,
   output logic        load,
   output logic [15:0] pi_data,
   output logic [1:0]  pi_length,
   output logic        pi_fill,
   output logic        pi_msb,
   output logic        pi_low,
   output logic        pi_end,
   input  logic        so_valid,
   output logic        busy,
   output logic        done,
   output logic [7:0]  word_cnt,
   output logic        len_err,
   output logic        timeout_err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_WAIT_START,
      S_SHIFT,
      S_FINISH
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic [15:0] r_pi_data;
   logic [1:0]  r_pi_length;
   logic        r_pi_fill;
   logic        r_pi_msb;
   logic        r_pi_low;
   logic        r_last;
   logic [5:0]  r_bit_cnt;
   logic [7:0]  r_word_cnt;
   logic        r_len_err;
   logic        w_accept;
   logic        w_burst_end;
   logic        w_timeout;
   logic [5:0]  w_exp_len;

   assign w_accept    = cmd_valid & (r_state == S_IDLE);
   assign w_burst_end = (r_state == S_SHIFT) & ~so_valid;
   assign w_exp_len   = {1'b0, r_pi_length, 3'b000} + 6'd8;

`ifdef STI_SEQ_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

   logic [TO_W-1:0] r_to_cnt;
   logic            r_timeout_err;

   assign w_timeout = (r_state == S_WAIT_START) & ~so_valid &
                      (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));

   // Counter restarts every LOAD, so it only measures the current word's wait.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_to_cnt      <= '0;
         r_timeout_err <= 1'b0;
      end else begin
         if (r_state == S_LOAD)
            r_to_cnt <= '0;
         else if (r_state == S_WAIT_START && !so_valid && !w_timeout)
            r_to_cnt <= r_to_cnt + 1'b1;
         if (w_timeout)
            r_timeout_err <= 1'b1;
      end
   end

   assign timeout_err = r_timeout_err;
`else
   assign w_timeout   = 1'b0;
   assign timeout_err = 1'b0;
`endif

   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk) begin
      if (reset)
         r_state <= S_IDLE;
      else
         r_state <= w_next;
   end

   // NOTE: every comb output gets a default before the case, so no latch can be inferred.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:       if (cmd_valid) w_next = S_LOAD;
         S_LOAD:       w_next = S_WAIT_START;
         S_WAIT_START: begin
            if (so_valid)
               w_next = S_SHIFT;
            else if (w_timeout)
               w_next = r_last ? S_FINISH : S_IDLE;
         end
         S_SHIFT:      if (!so_valid) w_next = r_last ? S_FINISH : S_IDLE;
         S_FINISH:     w_next = S_IDLE;
         default:      w_next = S_IDLE;
      endcase
   end

   always_comb begin
      cmd_ready = 1'b0;
      load      = 1'b0;
      done      = 1'b0;
      busy      = 1'b1;
      case (r_state)
         S_IDLE: begin
            cmd_ready = 1'b1;
            busy      = 1'b0;
         end
         S_LOAD:   load = 1'b1;
         S_FINISH: done = 1'b1;
         default:  ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_pi_data   <= 16'd0;
         r_pi_length <= 2'd0;
         r_pi_fill   <= 1'b0;
         r_pi_msb    <= 1'b0;
         r_pi_low    <= 1'b0;
         r_last      <= 1'b0;
         r_bit_cnt   <= 6'd0;
         r_word_cnt  <= 8'd0;
         r_len_err   <= 1'b0;
      end else begin
         if (w_accept) begin
            r_pi_data   <= cmd_data;
            r_pi_length <= cmd_length;
            r_pi_fill   <= cmd_fill;
            r_pi_msb    <= cmd_msb;
            r_pi_low    <= cmd_low;
            r_last      <= cmd_last;
            r_bit_cnt   <= 6'd0;
         end
         if (r_state == S_WAIT_START && so_valid)
            r_bit_cnt <= 6'd1;
         else if (r_state == S_SHIFT && so_valid && r_bit_cnt != 6'd63)
            r_bit_cnt <= r_bit_cnt + 6'd1;
         if (w_burst_end && r_bit_cnt != w_exp_len)
            r_len_err <= 1'b1;
         if (w_burst_end || w_timeout)
            r_word_cnt <= r_word_cnt + 8'd1;
      end
   end

   // pi_end mirrors the registered last flag, which only changes on accept.
   assign pi_data   = r_pi_data;
   assign pi_length = r_pi_length;
   assign pi_fill   = r_pi_fill;
   assign pi_msb    = r_pi_msb;
   assign pi_low    = r_pi_low;
   assign pi_end    = r_last;
   assign word_cnt  = r_word_cnt;
   assign len_err   = r_len_err;

endmodule

// File: tb/tb_sti_seq_ctrl.sv
// Directed self-checking bench for sti_seq_ctrl; the timeout scenario follows STI_SEQ_TIMEOUT_EN.
module tb_sti_seq_ctrl;
   localparam int TO_CYC = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [15:0] cmd_data;
   logic [1:0]  cmd_length;
   logic        cmd_fill;
   logic        cmd_msb;
   logic        cmd_low;
   logic        cmd_last;
   logic        load;
   logic [15:0] pi_data;
   logic [1:0]  pi_length;
   logic        pi_fill;
   logic        pi_msb;
   logic        pi_low;
   logic        pi_end;
   logic        so_valid;
   logic        busy;
   logic        done;
   logic [7:0]  word_cnt;
   logic        len_err;
   logic        timeout_err;

   int n_pass  = 0;
   int n_total = 0;

   sti_seq_ctrl #(.TIMEOUT_CYC(TO_CYC)) u_dut (
      .clk         (clk),
      .reset       (reset),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_data    (cmd_data),
      .cmd_length  (cmd_length),
      .cmd_fill    (cmd_fill),
      .cmd_msb     (cmd_msb),
      .cmd_low     (cmd_low),
      .cmd_last    (cmd_last),
      .load        (load),
      .pi_data     (pi_data),
      .pi_length   (pi_length),
      .pi_fill     (pi_fill),
      .pi_msb      (pi_msb),
      .pi_low      (pi_low),
      .pi_end      (pi_end),
      .so_valid    (so_valid),
      .busy        (busy),
      .done        (done),
      .word_cnt    (word_cnt),
      .len_err     (len_err),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs === exp)
         n_pass++;
      else
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   // Inputs change and outputs are sampled 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      cmd_valid = 1'b0;
      so_valid  = 1'b0;
      step();
      step();
      reset = 1'b0;
   endtask

   // so_valid rises in the LOAD cycle; that cycle must not be counted.
   task automatic run_word(input string tag, input logic [15:0] data, input logic [1:0] len,
                           input logic [2:0] mode, input logic last, input int nbits);
      check({tag, ".ready_pre"}, cmd_ready, 1);
      cmd_valid  = 1'b1;
      cmd_data   = data;
      cmd_length = len;
      {cmd_fill, cmd_msb, cmd_low} = mode;
      cmd_last   = last;
      step();
      cmd_valid = 1'b0;
      cmd_data  = ~data;
      check({tag, ".load"}, load, 1);
      check({tag, ".pi_data"}, pi_data, data);
      check({tag, ".pi_length"}, pi_length, len);
      check({tag, ".pi_mode"}, {pi_fill, pi_msb, pi_low}, mode);
      check({tag, ".pi_end"}, pi_end, last);
      check({tag, ".busy"}, {cmd_ready, busy}, 2'b01);
      so_valid = 1'b1;
      step();
      check({tag, ".load_gone"}, load, 0);
      repeat (nbits) step();
      so_valid = 1'b0;
      step();
      if (last) begin
         check({tag, ".done"}, {done, cmd_ready}, 2'b10);
         step();
         check({tag, ".done_end"}, {done, cmd_ready}, 2'b01);
      end else begin
         check({tag, ".ready_post"}, {done, cmd_ready}, 2'b01);
      end
   endtask

   initial begin
      cmd_data   = 16'd0;
      cmd_length = 2'd0;
      cmd_fill   = 1'b0;
      cmd_msb    = 1'b0;
      cmd_low    = 1'b0;
      cmd_last   = 1'b0;
      do_reset();

      check("rst.ctrl", {cmd_ready, busy, load, done, pi_end}, 5'b10000);
      check("rst.err", {len_err, timeout_err}, 2'b00);
      check("rst.pi", {pi_data, pi_length, pi_fill, pi_msb, pi_low}, 21'd0);
      check("rst.word_cnt", word_cnt, 0);

      // Single 8-bit last word
      run_word("single", 16'h00A5, 2'd0, 3'b101, 1'b1, 8);
      check("single.word_cnt", word_cnt, 1);
      check("single.len_err", len_err, 0);
      check("single.pi_end_hold", pi_end, 1);

      // Four-word frame, lengths 0..3
      do_reset();
      run_word("frm0", 16'h1234, 2'd0, 3'b000, 1'b0, 8);
      check("frm0.pi_end", pi_end, 0);
      run_word("frm1", 16'hBEEF, 2'd1, 3'b010, 1'b0, 16);
      run_word("frm2", 16'h0F0F, 2'd2, 3'b001, 1'b0, 24);
      check("frm2.pi_end", pi_end, 0);
      run_word("frm3", 16'h8001, 2'd3, 3'b100, 1'b1, 32);
      check("frm.word_cnt", word_cnt, 4);
      check("frm.len_err", len_err, 0);
      check("frm.pi_end_hold", pi_end, 1);

      // Length mismatch is sticky until reset
      do_reset();
      run_word("short", 16'h5555, 2'd1, 3'b000, 1'b0, 15);
      check("short.len_err", len_err, 1);
      run_word("good_after", 16'h6666, 2'd0, 3'b000, 1'b0, 8);
      check("sticky.len_err", len_err, 1);
      check("sticky.word_cnt", word_cnt, 2);
      do_reset();
      check("len_err.cleared", len_err, 0);

      // 96 bits saturates at 63 rather than wrapping back to 32
      run_word("sat", 16'h7777, 2'd3, 3'b000, 1'b0, 96);
      check("sat.len_err", len_err, 1);

      // cmd_valid held with new data during the burst
      do_reset();
      cmd_valid  = 1'b1;
      cmd_data   = 16'h1111;
      cmd_length = 2'd0;
      cmd_last   = 1'b0;
      step();
      cmd_data = 16'h2222;
      so_valid = 1'b1;
      step();
      repeat (8) step();
      check("hold.pi_data_shift", pi_data, 16'h1111);
      check("hold.ready_shift", cmd_ready, 0);
      so_valid = 1'b0;
      step();
      check("hold.ready_idle", cmd_ready, 1);
      check("hold.pi_data_idle", pi_data, 16'h1111);
      step();
      cmd_valid = 1'b0;
      check("hold.load2", load, 1);
      check("hold.pi_data2", pi_data, 16'h2222);
      so_valid = 1'b1;
      step();
      repeat (8) step();
      so_valid = 1'b0;
      step();
      check("hold.word_cnt", word_cnt, 2);
      check("hold.len_err", len_err, 0);

      // Reset in the middle of a 24-bit burst
      do_reset();
      cmd_valid  = 1'b1;
      cmd_data   = 16'hCAFE;
      cmd_length = 2'd2;
      {cmd_fill, cmd_msb, cmd_low} = 3'b111;
      cmd_last   = 1'b1;
      step();
      cmd_valid = 1'b0;
      so_valid  = 1'b1;
      step();
      repeat (10) step();
      check("mid.busy_shift", busy, 1);
      reset = 1'b1;
      step();
      reset    = 1'b0;
      so_valid = 1'b0;
      check("mid.ctrl", {cmd_ready, busy, load, done, pi_end}, 5'b10000);
      check("mid.pi", {pi_data, pi_length, pi_fill, pi_msb, pi_low}, 21'd0);
      check("mid.cnt_err", {word_cnt, len_err}, 9'd0);
      step();
      check("mid.idle_stable", {cmd_ready, word_cnt, len_err}, {1'b1, 9'd0});
      run_word("mid_after", 16'h0042, 2'd0, 3'b000, 1'b0, 8);
      check("mid_after.cnt_err", {word_cnt, len_err}, {8'd1, 1'b0});

      // word_cnt wraps from 255 to 0
      do_reset();
      for (int i = 0; i < 255; i++) begin
         run_word("wrap", 16'(i), 2'd0, 3'b000, 1'b0, 8);
      end
      check("wrap.255", word_cnt, 255);
      run_word("wrap_last", 16'hFFFF, 2'd0, 3'b000, 1'b0, 8);
      check("wrap.0", word_cnt, 0);

      // No so_valid response after load
      do_reset();
      cmd_valid  = 1'b1;
      cmd_data   = 16'h0BAD;
      cmd_length = 2'd0;
      cmd_last   = 1'b0;
      step();
      cmd_valid = 1'b0;
      step();
`ifdef STI_SEQ_TIMEOUT_EN
      repeat (TO_CYC - 1) step();
      check("to.before", {busy, timeout_err, word_cnt}, {1'b1, 1'b0, 8'd0});
      step();
      check("to.after", {cmd_ready, busy, timeout_err}, 3'b101);
      check("to.word_cnt", word_cnt, 1);
      check("to.len_err", len_err, 0);
`else
      repeat (1000) step();
      check("noto.waiting", {cmd_ready, busy}, 2'b01);
      check("noto.timeout_err", timeout_err, 0);
      check("noto.word_cnt", word_cnt, 0);
`endif
      do_reset();
      check("final.idle", cmd_ready, 1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/sti_seq_ctrl.md
# sti_seq_ctrl

Host-side sequencer for the STI_DAC serializer. Accepts configured 16-bit words from a requester over a valid/ready handshake. Drives them into STI_DAC as one-cycle `load` transactions, then tracks the resulting `so_valid` burst and checks its length against `pi_length`. Asserts `pi_end` with the final word so the DAC/OEM memory stage can flush and raise `oem_finish`.

## Interface
- `TIMEOUT_CYC`, default 64: watchdog limit, in cycles, for `so_valid` to rise after `load`. Used only with `STI_SEQ_TIMEOUT_EN`.
- `clk`, input, 1: single clock; all logic uses the rising edge.
- `reset`, input, 1: synchronous, active-high.
- `cmd_valid`, input, 1: requester has a word.
- `cmd_ready`, output, 1: sequencer can accept a word.
- `cmd_data`, input, 16: parallel data word.
- `cmd_length`, input, 2: serial length code; 0 = 8, 1 = 16, 2 = 24, 3 = 32 bits.
- `cmd_fill`, `cmd_msb`, `cmd_low`, input, 1 each: fill mode, MSB-first, low-byte select.
- `cmd_last`, input, 1: this word ends the frame.
- `load`, output, 1: one-cycle load strobe to STI_DAC.
- `pi_data`, output, 16: registered copy of `cmd_data`.
- `pi_length`, output, 2: registered copy of `cmd_length`.
- `pi_fill`, `pi_msb`, `pi_low`, output, 1 each: registered copies of the command mode bits.
- `pi_end`, output, 1: end-of-frame flag to STI_DAC.
- `so_valid`, input, 1: serial-valid from STI_DAC.
- `busy`, output, 1: high in every state except IDLE.
- `done`, output, 1: one-cycle pulse when a `cmd_last` word completes.
- `word_cnt`, output, 8: number of words completed.
- `len_err`, output, 1: sticky; a burst length mismatched its length code.
- `timeout_err`, output, 1: sticky; the watchdog expired.

## Operation
- States: IDLE, LOAD, WAIT_START, SHIFT, FINISH.
- **IDLE**
  - `cmd_ready` = 1.
  - On `cmd_valid & cmd_ready`: register all `cmd_*` fields onto `pi_*`, register `last`, then go to LOAD.
  - `pi_end` clears on this accept unless the new word has `cmd_last` = 1.
- **LOAD**
  - `load` = 1 for exactly this cycle.
  - `pi_end` = registered `last`; it stays at that value until the next accept.
  - Go to WAIT_START.
- **WAIT_START**
  - When `so_valid` = 1 is sampled: bit counter = 1, go to SHIFT.
  - Otherwise stay (see Configuration for the timeout).
- **SHIFT**
  - Each cycle with `so_valid` = 1: bit counter +1. The counter is 6 bits and saturates at 63.
  - On the first cycle with `so_valid` = 0: compare the count against `8*(pi_length+1)`. On mismatch, set `len_err`.
  - In the same cycle: `word_cnt` +1, wrapping from 255 to 0.
  - Next state is FINISH if `last`, else IDLE.
- **FINISH**
  - `done` = 1 for this cycle only; go to IDLE.
- `pi_*` outputs hold their values from accept until the next accept. They are never changed while `busy`.
- `cmd_valid` while `cmd_ready` = 0 is ignored. The requester must hold its word until accepted.
- `len_err` and `timeout_err` clear only on `reset`.
- The bit counter is cleared on every accept.

## Timing
- Reset values:
  - state IDLE; `cmd_ready` = 1.
  - `load`, `pi_end`, `done`, `busy`, `len_err`, `timeout_err` = 0.
  - `pi_data` = 0, `pi_length` = 0, `pi_fill`/`pi_msb`/`pi_low` = 0, `word_cnt` = 0.
- Reset mid-operation (any state): everything returns to the reset values on the next edge. A `so_valid` burst in progress is not counted.
- Accept at edge N:
  - `load` and `pi_*` are valid in cycle N+1.
  - `cmd_ready` and `busy` go to 0/1 from cycle N+1.
- `so_valid` may rise in the LOAD cycle itself. It is not sampled until WAIT_START, so it is counted from the first WAIT_START edge.
- The burst ends at edge M (first `so_valid` = 0 in SHIFT):
  - `word_cnt` and `len_err` update at M.
  - Non-last word: `cmd_ready` = 1 in cycle M+1.
  - Last word: `done` = 1 in cycle M+1 and `cmd_ready` = 1 in cycle M+2.
- Back-to-back words are allowed: the next accept can occur in the first cycle of IDLE.

## Configuration
- **With `STI_SEQ_TIMEOUT_EN` defined**
  - A counter runs in WAIT_START. After `TIMEOUT_CYC` consecutive cycles without `so_valid`: set `timeout_err`, increment `word_cnt`, and leave WAIT_START.
  - The exit goes to FINISH if `last`, else IDLE.
  - No length check is made for that word.
- **Without the macro**
  - WAIT_START waits indefinitely.
  - `timeout_err` is tied to 0 and the counter logic is absent.

## Test plan
- Single 8-bit word: `cmd_data`=0x00A5, `cmd_length`=0, `cmd_last`=1; STI returns a 8-cycle `so_valid` burst -> `load` high exactly 1 cycle, `pi_end`=1, `done` pulse once, `word_cnt`=1, `len_err`=0.
- Frame of 4 words with lengths 0/1/2/3 and bursts of 8/16/24/32 -> `word_cnt`=4; `pi_end` high only from the 4th word's LOAD onward; no `len_err`.
- 16-bit code (`cmd_length`=1) with a 15-cycle burst -> `len_err`=1 and stays 1 through later correct words until `reset`.
- `cmd_valid` held high during SHIFT with a different `cmd_data` -> `pi_data` unchanged until the return to IDLE; the second word is accepted the cycle after the burst ends.
- `reset` pulsed in mid-SHIFT (after 10 of 24 bits) -> next cycle IDLE, `cmd_ready`=1, `word_cnt`=0, `pi_*`=0, no `len_err`.
- With `STI_SEQ_TIMEOUT_EN`, `TIMEOUT_CYC`=16, no `so_valid` response -> `timeout_err`=1 after 16 WAIT_START cycles, `word_cnt`=1, `cmd_ready` returns high; without the macro, still in WAIT_START after 1000 cycles with `timeout_err`=0.
